// File: rtl/awg_cmd_pkg.sv
// Shared constants for the AWG command parser: ASCII codes, FSM state
// encoding, field indices and a character classifier.
package awg_cmd_pkg;

    localparam logic [7:0] CH_0     = 8'h30;
    localparam logic [7:0] CH_9     = 8'h39;
    localparam logic [7:0] CH_COMMA = 8'h2C;
    localparam logic [7:0] CH_SEMI  = 8'h3B;
    localparam logic [7:0] CH_LF    = 8'h0A;
    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_SP    = 8'h20;
    localparam logic [7:0] CH_CLR   = 8'h64;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FIELD = 2'd1;
    localparam logic [1:0] ERROR = 2'd2;

    localparam logic [1:0] F_WAVE  = 2'd0;
    localparam logic [1:0] F_FREQ  = 2'd1;
    localparam logic [1:0] F_AMP   = 2'd2;
    localparam logic [1:0] F_PHASE = 2'd3;

    localparam int NUM_FIELDS = 4;

    typedef enum logic [2:0] {
        CC_DIGIT,
        CC_SEP,
        CC_TERM,
        CC_CLR,
        CC_IGN,
        CC_BAD
    } char_class_t;

    function automatic char_class_t classify(input logic [7:0] ch);
        if (ch >= CH_0 && ch <= CH_9)       return CC_DIGIT;
        if (ch == CH_COMMA)                 return CC_SEP;
        if (ch == CH_SEMI || ch == CH_LF)   return CC_TERM;
        if (ch == CH_CLR)                   return CC_CLR;
        if (ch == CH_CR || ch == CH_SP)     return CC_IGN;
        return CC_BAD;
    endfunction

endpackage

// File: rtl/awg_strobe_sync.sv
// Brings the asynchronous UART byte-ready strobe into the clk domain with a
// two-flop synchroniser and emits a one-cycle pulse on its rising edge. The
// pulse is high during the third clock after rd rises.
module awg_strobe_sync (
    input  logic clk,
    input  logic rst,
    input  logic i_rd,
    output logic o_pulse
);

    logic [2:0] r_sync;

    // Shift rd through two metastability flops plus one history flop
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= 3'b000;
        end else begin
            r_sync <= {r_sync[1:0], i_rd};
        end
    end

    assign o_pulse = r_sync[1] & ~r_sync[2];

endmodule

// File: rtl/awg_cmd_parser.sv
// ASCII command parser for the AWG control path. Parses
// "wave,freq,amp,phase" decimal fields, range-checks each one and commits
// all four atomically on ';' or LF. 'd' restores the defaults.
// Optional build macro AWG_CMD_TIMEOUT_EN: aborts a partial command after
// TIMEOUT_CYC idle cycles and reports it on cmd_err.
module awg_cmd_parser
    import awg_cmd_pkg::*;
#(
    parameter int                 WAVE_W      = 3,
    parameter int                 FREQ_W      = 12,
    parameter int                 AMP_W       = 4,
    parameter int                 PHASE_W     = 8,
    parameter int                 MAX_DIGITS  = 5,
    parameter logic [WAVE_W-1:0]  DEF_WAVE    = '0,
    parameter logic [FREQ_W-1:0]  DEF_FREQ    = '0,
    parameter logic [AMP_W-1:0]   DEF_AMP     = '0,
    parameter logic [PHASE_W-1:0] DEF_PHASE   = '0,
    parameter int                 TIMEOUT_CYC = 1000000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         cmd,
    input  logic               rd,
    output logic [WAVE_W-1:0]  state,
    output logic [FREQ_W-1:0]  state_freq,
    output logic [AMP_W-1:0]   state_amp,
    output logic [PHASE_W-1:0] state_phase,
    output logic               cmd_upd,
    output logic               cmd_err,
    output logic               busy
);

    // Elaboration-time sanity checks on the configuration
    if (MAX_DIGITS < 1 || MAX_DIGITS > 5) begin : g_bad_digits
        $error("awg_cmd_parser: MAX_DIGITS must be in 1..5");
    end
    if (TIMEOUT_CYC < 2) begin : g_bad_timeout
        $error("awg_cmd_parser: TIMEOUT_CYC must be at least 2");
    end

    logic                w_strobe;
    char_class_t         w_cls;
    logic [7:0]          w_digit;
    logic [16:0]         w_acc_next;
    logic                w_fits;
    logic                w_clear;
    logic                w_commit;
    logic                w_reject;
    logic                w_timeout;
    logic                w_busy;

    logic [1:0]          r_fsm;
    logic [1:0]          r_idx;
    logic [16:0]         r_acc;
    logic [2:0]          r_cnt;
    logic [3:0]          r_set;

    logic [WAVE_W-1:0]   r_sh_wave;
    logic [FREQ_W-1:0]   r_sh_freq;
    logic [AMP_W-1:0]    r_sh_amp;
    logic [PHASE_W-1:0]  r_sh_phase;

    logic [WAVE_W-1:0]   r_wave,  w_new_wave;
    logic [FREQ_W-1:0]   r_freq,  w_new_freq;
    logic [AMP_W-1:0]    r_amp,   w_new_amp;
    logic [PHASE_W-1:0]  r_phase, w_new_phase;
    logic                r_upd;
    logic                r_err;

    // True when the accumulated value fits the output width of field idx
    function automatic logic fits(input logic [1:0] idx, input logic [16:0] v);
        case (idx)
            F_WAVE:  return (v >> WAVE_W)  == 17'd0;
            F_FREQ:  return (v >> FREQ_W)  == 17'd0;
            F_AMP:   return (v >> AMP_W)   == 17'd0;
            default: return (v >> PHASE_W) == 17'd0;
        endcase
    endfunction

    awg_strobe_sync u_sync (
        .clk     (clk),
        .rst     (rst),
        .i_rd    (rd),
        .o_pulse (w_strobe)
    );

    assign w_cls      = classify(cmd);
    assign w_digit    = cmd - CH_0;
    assign w_acc_next = r_acc * 17'd10 + {9'd0, w_digit};
    assign w_fits     = fits(r_idx, r_acc);
    assign w_busy     = (r_fsm != IDLE);

    // Clear is honoured in every state; a terminator either commits or rejects
    assign w_clear  = w_strobe && (w_cls == CC_CLR);
    assign w_commit = w_strobe && (w_cls == CC_TERM) && (r_fsm == FIELD) && w_fits;
    assign w_reject = (w_strobe && (w_cls == CC_TERM) &&
                       (((r_fsm == FIELD) && !w_fits) || (r_fsm == ERROR)))
                      || w_timeout;

`ifdef AWG_CMD_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TO_W-1:0] r_to_cnt;

    // Idle counter: runs while a command is open, restarts on every character
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_to_cnt <= '0;
        end else if (!w_busy || w_strobe) begin
            r_to_cnt <= '0;
        end else begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
        end
    end

    assign w_timeout = w_busy && !w_strobe && (r_to_cnt == TO_W'(TIMEOUT_CYC - 1));
`else
    assign w_timeout = 1'b0;
`endif

    // Values presented on commit: the field being closed takes the
    // accumulator, earlier non-empty fields their shadow, the rest hold
    always_comb begin
        w_new_wave  = r_set[F_WAVE]  ? r_sh_wave  : r_wave;
        w_new_freq  = r_set[F_FREQ]  ? r_sh_freq  : r_freq;
        w_new_amp   = r_set[F_AMP]   ? r_sh_amp   : r_amp;
        w_new_phase = r_set[F_PHASE] ? r_sh_phase : r_phase;
        if (r_cnt != 3'd0) begin
            case (r_idx)
                F_WAVE:  w_new_wave  = r_acc[WAVE_W-1:0];
                F_FREQ:  w_new_freq  = r_acc[FREQ_W-1:0];
                F_AMP:   w_new_amp   = r_acc[AMP_W-1:0];
                default: w_new_phase = r_acc[PHASE_W-1:0];
            endcase
        end
    end

    // Parser state, field accumulator and per-field shadow registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fsm      <= IDLE;
            r_idx      <= F_WAVE;
            r_acc      <= '0;
            r_cnt      <= '0;
            r_set      <= '0;
            r_sh_wave  <= DEF_WAVE;
            r_sh_freq  <= DEF_FREQ;
            r_sh_amp   <= DEF_AMP;
            r_sh_phase <= DEF_PHASE;
        end else if (w_strobe) begin
            if (w_cls == CC_CLR) begin
                r_fsm <= IDLE;
            end else begin
                case (r_fsm)
                    IDLE: begin
                        case (w_cls)
                            CC_DIGIT: begin
                                r_fsm <= FIELD;
                                r_idx <= F_WAVE;
                                r_acc <= {9'd0, w_digit};
                                r_cnt <= 3'd1;
                                r_set <= '0;
                            end
                            CC_SEP: begin
                                r_fsm <= FIELD;
                                r_idx <= F_FREQ;
                                r_acc <= '0;
                                r_cnt <= '0;
                                r_set <= '0;
                            end
                            CC_BAD:  r_fsm <= ERROR;
                            default: ;
                        endcase
                    end
                    FIELD: begin
                        case (w_cls)
                            CC_DIGIT: begin
                                if (r_cnt == 3'(MAX_DIGITS)) begin
                                    r_fsm <= ERROR;
                                end else begin
                                    r_acc <= w_acc_next;
                                    r_cnt <= r_cnt + 3'd1;
                                end
                            end
                            CC_SEP: begin
                                if (!w_fits || r_idx == 2'(NUM_FIELDS - 1)) begin
                                    r_fsm <= ERROR;
                                end else begin
                                    if (r_cnt != 3'd0) begin
                                        r_set[r_idx] <= 1'b1;
                                        case (r_idx)
                                            F_WAVE:  r_sh_wave  <= r_acc[WAVE_W-1:0];
                                            F_FREQ:  r_sh_freq  <= r_acc[FREQ_W-1:0];
                                            F_AMP:   r_sh_amp   <= r_acc[AMP_W-1:0];
                                            default: r_sh_phase <= r_acc[PHASE_W-1:0];
                                        endcase
                                    end
                                    r_idx <= r_idx + 2'd1;
                                    r_acc <= '0;
                                    r_cnt <= '0;
                                end
                            end
                            CC_TERM: r_fsm <= IDLE;
                            CC_BAD:  r_fsm <= ERROR;
                            default: ;
                        endcase
                    end
                    ERROR: begin
                        if (w_cls == CC_TERM) begin
                            r_fsm <= IDLE;
                        end
                    end
                    default: r_fsm <= IDLE;
                endcase
            end
        end else if (w_timeout) begin
            r_fsm <= IDLE;
        end
    end

    // Committed outputs and the update/error strobes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wave  <= DEF_WAVE;
            r_freq  <= DEF_FREQ;
            r_amp   <= DEF_AMP;
            r_phase <= DEF_PHASE;
            r_upd   <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            if (w_clear) begin
                r_wave  <= DEF_WAVE;
                r_freq  <= DEF_FREQ;
                r_amp   <= DEF_AMP;
                r_phase <= DEF_PHASE;
            end else if (w_commit) begin
                r_wave  <= w_new_wave;
                r_freq  <= w_new_freq;
                r_amp   <= w_new_amp;
                r_phase <= w_new_phase;
            end
            r_upd <= w_clear | w_commit;
            r_err <= w_reject & ~w_clear;
        end
    end

    assign state       = r_wave;
    assign state_freq  = r_freq;
    assign state_amp   = r_amp;
    assign state_phase = r_phase;
    assign cmd_upd     = r_upd;
    assign cmd_err     = r_err;
    assign busy        = w_busy;

endmodule

// File: tb/tb_awg_cmd_parser.sv
// Testbench for awg_cmd_parser: directed command strings from the test plan
// plus randomized commands, checked against a string-level command model.
module tb_awg_cmd_parser;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rd  = 1'b0;
    logic [7:0]  cmd = 8'h00;
    logic [2:0]  state;
    logic [11:0] state_freq;
    logic [3:0]  state_amp;
    logic [7:0]  state_phase;
    logic        cmd_upd;
    logic        cmd_err;
    logic        busy;
    logic [26:0] dut_outs;

    int checks = 0;
    int errors = 0;
    int upd_seen = 0;
    int err_seen = 0;
    int both_seen = 0;

    // Reference model state
    int  m_wave = 0, m_freq = 0, m_amp = 0, m_phase = 0;
    int  m_upd = 0, m_err = 0;
    byte m_q[$];
    int  lim[4] = '{7, 4095, 15, 255};

    awg_cmd_parser #(.TIMEOUT_CYC(50)) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd         (cmd),
        .rd          (rd),
        .state       (state),
        .state_freq  (state_freq),
        .state_amp   (state_amp),
        .state_phase (state_phase),
        .cmd_upd     (cmd_upd),
        .cmd_err     (cmd_err),
        .busy        (busy)
    );

    assign dut_outs = {state, state_freq, state_amp, state_phase};

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (cmd_upd) upd_seen <= upd_seen + 1;
        if (cmd_err) err_seen <= err_seen + 1;
        if (cmd_upd && cmd_err) both_seen <= both_seen + 1;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: time limit reached, required finish before 900000");
        $fatal(1);
    end

    function automatic logic [26:0] m_outs();
        return {m_wave[2:0], m_freq[11:0], m_amp[3:0], m_phase[7:0]};
    endfunction

    function automatic bit m_busy();
        return m_q.size() != 0;
    endfunction

    // Evaluate a whole buffered command against the field rules
    function automatic void m_eval();
        int  vals[4];
        bit  has[4];
        int  f, nd, v;
        bit  bad;
        f = 0; nd = 0; v = 0; bad = 0;
        for (int k = 0; k < 4; k++) begin vals[k] = 0; has[k] = 0; end
        for (int i = 0; i <= m_q.size(); i++) begin
            if (i == m_q.size() || m_q[i] == 8'h2C) begin
                if (nd > 5 || f >= 4) bad = 1;
                else if (nd > 0) begin
                    if (v > lim[f]) bad = 1;
                    else begin vals[f] = v; has[f] = 1; end
                end
                f++; nd = 0; v = 0;
            end else if (m_q[i] >= 8'h30 && m_q[i] <= 8'h39) begin
                nd++;
                if (nd <= 5) v = v * 10 + (m_q[i] - 48);
            end else begin
                bad = 1;
            end
        end
        if (bad) m_err++;
        else begin
            if (has[0]) m_wave  = vals[0];
            if (has[1]) m_freq  = vals[1];
            if (has[2]) m_amp   = vals[2];
            if (has[3]) m_phase = vals[3];
            m_upd++;
        end
        m_q.delete();
    endfunction

    function automatic void m_char(byte c);
        if (c == 8'h0D || c == 8'h20) return;
        if (c == 8'h64) begin
            m_wave = 0; m_freq = 0; m_amp = 0; m_phase = 0;
            m_upd++;
            m_q.delete();
        end else if (c == 8'h3B || c == 8'h0A) begin
            if (m_q.size() != 0) m_eval();
        end else begin
            m_q.push_back(c);
        end
    endfunction

    task automatic send_char(input byte c);
        m_char(c);
        cmd = c;
        rd  = 1'b1;
        repeat (5) @(negedge clk);
        rd  = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_char(s[i]);
    endtask

    task automatic test_reset();
        checks++;
        if (dut_outs !== 27'd0) begin errors++; $display("FAIL reset_outs: got %h required 0", dut_outs); end
        checks++;
        if ({cmd_upd, cmd_err, busy} !== 3'b000) begin
            errors++; $display("FAIL reset_flags: got upd/err/busy %b required 000", {cmd_upd, cmd_err, busy});
        end
    endtask

    task automatic test_full_cmd();
        send_str("1,1000,8,64;");
        checks++;
        if (dut_outs !== {3'd1, 12'd1000, 4'd8, 8'd64}) begin
            errors++; $display("FAIL full_outs: got %h required %h", dut_outs, {3'd1, 12'd1000, 4'd8, 8'd64});
        end
        checks++;
        if (upd_seen !== 1) begin errors++; $display("FAIL full_upd: got %0d pulses required 1", upd_seen); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL full_busy: got %b required 0", busy); end
    endtask

    task automatic test_partial();
        send_str(",2000;\r\n");
        checks++;
        if (dut_outs !== {3'd1, 12'd2000, 4'd8, 8'd64}) begin
            errors++; $display("FAIL partial_outs: got %h required %h", dut_outs, {3'd1, 12'd2000, 4'd8, 8'd64});
        end
        checks++;
        if (upd_seen !== 2) begin errors++; $display("FAIL partial_upd: got %0d pulses required 2", upd_seen); end
    endtask

    task automatic test_range_err();
        send_str("0,5000,1,1;");
        checks++;
        if (dut_outs !== {3'd1, 12'd2000, 4'd8, 8'd64}) begin
            errors++; $display("FAIL range_outs: got %h required %h", dut_outs, {3'd1, 12'd2000, 4'd8, 8'd64});
        end
        checks++;
        if (err_seen !== 1) begin errors++; $display("FAIL range_err: got %0d pulses required 1", err_seen); end
        checks++;
        if (upd_seen !== 2) begin errors++; $display("FAIL range_upd: got %0d pulses required 2", upd_seen); end
    endtask

    task automatic test_errors();
        send_str("1,1,1,1,1;");
        checks++;
        if (err_seen !== 2) begin errors++; $display("FAIL five_fields_err: got %0d required 2", err_seen); end
        send_str("2,123456;");
        checks++;
        if (err_seen !== 3) begin errors++; $display("FAIL six_digits_err: got %0d required 3", err_seen); end
        send_str("3,x;");
        checks++;
        if (err_seen !== 4) begin errors++; $display("FAIL invalid_char_err: got %0d required 4", err_seen); end
        checks++;
        if (dut_outs !== {3'd1, 12'd2000, 4'd8, 8'd64} || upd_seen !== 2) begin
            errors++; $display("FAIL errors_hold: got outs %h upd %0d required %h upd 2", dut_outs, upd_seen,
                               {3'd1, 12'd2000, 4'd8, 8'd64});
        end
    endtask

    task automatic test_clear();
        send_str("2,30");
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL clear_busy_mid: got %b required 1", busy); end
        send_char("d");
        checks++;
        if (dut_outs !== 27'd0) begin errors++; $display("FAIL clear_outs: got %h required 0", dut_outs); end
        checks++;
        if (upd_seen !== 3 || busy !== 1'b0) begin
            errors++; $display("FAIL clear_upd_busy: got upd %0d busy %b required 3 and 0", upd_seen, busy);
        end
    endtask

    task automatic test_async_reset();
        send_str("5,7,9,11;");
        checks++;
        if (dut_outs !== m_outs()) begin errors++; $display("FAIL prereset_outs: got %h required %h", dut_outs, m_outs()); end
        send_str("3,10");
        #2 rst = 1'b1;
        #1;
        m_wave = 0; m_freq = 0; m_amp = 0; m_phase = 0; m_q.delete();
        checks++;
        if (dut_outs !== 27'd0 || busy !== 1'b0) begin
            errors++; $display("FAIL async_reset: got outs %h busy %b required 0 and 0", dut_outs, busy);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        send_str("1,2,3,4;");
        checks++;
        if (dut_outs !== {3'd1, 12'd2, 4'd3, 8'd4}) begin
            errors++; $display("FAIL post_reset_outs: got %h required %h", dut_outs, {3'd1, 12'd2, 4'd3, 8'd4});
        end
        checks++;
        if (upd_seen !== m_upd) begin errors++; $display("FAIL post_reset_upd: got %0d required %0d", upd_seen, m_upd); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            int nf;
            int r;
            nf = $urandom_range(1, 5);
            for (int fi = 0; fi < nf; fi++) begin
                int l;
                l = (fi < 4) ? lim[fi] : 7;
                if (fi > 0) send_char(",");
                r = $urandom_range(0, 9);
                if (r == 1) send_str($sformatf("%0d", $urandom_range(100000, 999999)));
                else if (r == 2) send_char("q");
                else if (r > 2) send_str($sformatf("%0d", $urandom_range(0, l + l / 4 + 1)));
                if ($urandom_range(0, 7) == 0) send_char(" ");
                if ($urandom_range(0, 9) == 0) send_char(8'h0D);
            end
            r = $urandom_range(0, 9);
            if (r == 0) send_char("d");
            else if (r < 5) send_char(8'h0A);
            else send_char(";");
            checks++;
            if (dut_outs !== m_outs()) begin errors++; $display("FAIL rand_outs[%0d]: got %h required %h", n, dut_outs, m_outs()); end
            checks++;
            if (upd_seen !== m_upd) begin errors++; $display("FAIL rand_upd[%0d]: got %0d required %0d", n, upd_seen, m_upd); end
            checks++;
            if (err_seen !== m_err) begin errors++; $display("FAIL rand_err[%0d]: got %0d required %0d", n, err_seen, m_err); end
            checks++;
            if (busy !== m_busy()) begin errors++; $display("FAIL rand_busy[%0d]: got %b required %b", n, busy, m_busy()); end
        end
    endtask

`ifdef AWG_CMD_TIMEOUT_EN
    task automatic test_timeout();
        send_str("1,2");
        repeat (40) @(negedge clk);
        checks++;
        if (err_seen !== m_err || busy !== 1'b1) begin
            errors++; $display("FAIL timeout_early: got err %0d busy %b required %0d and 1", err_seen, busy, m_err);
        end
        repeat (20) @(negedge clk);
        m_q.delete();
        m_err++;
        checks++;
        if (err_seen !== m_err || busy !== 1'b0) begin
            errors++; $display("FAIL timeout_abort: got err %0d busy %b required %0d and 0", err_seen, busy, m_err);
        end
        checks++;
        if (dut_outs !== m_outs()) begin errors++; $display("FAIL timeout_outs: got %h required %h", dut_outs, m_outs()); end
    endtask
`endif

    initial begin
        repeat (3) @(negedge clk);
        test_reset();
        rst = 1'b0;
        @(negedge clk);
        m_q.delete();
        test_full_cmd();
        m_upd = upd_seen;
        m_err = err_seen;
        m_wave = 1; m_freq = 1000; m_amp = 8; m_phase = 64;
        test_partial();
        test_range_err();
        test_errors();
        test_clear();
        test_async_reset();
        test_random();
`ifdef AWG_CMD_TIMEOUT_EN
        test_timeout();
`endif
        checks++;
        if (both_seen !== 0) begin errors++; $display("FAIL upd_err_overlap: got %0d cycles required 0", both_seen); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
